bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/seg_pkg.sv | 24 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// Module  : seg_pkg
// Brief   : Shared constants and FSM encoding for the sequential BCD converter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam int BIN_W_DEF        = 32;
  localparam int DIGITS_DEF       = 8;
  // Two spare accumulator digits hold the part of a 32-bit value above 10^8.
  localparam int ACC_EXTRA_DIGITS = 2;
  localparam int ITERS            = BIN_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module  : bcd_digit_adj
// Brief   : Double-dabble correction for one BCD digit (add 3 when >= 5).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential double-dabble binary to packed BCD converter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  busy
);

  localparam int ACC_D  = DIGITS + ACC_EXTRA_DIGITS;
  localparam int ACC_W  = 4 * ACC_D;
  localparam int N_ITER = ITERS + (BIN_W - BIN_W_DEF);
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  state_e               state_q, state_d;
  logic [BIN_W-1:0]     sr_q, sr_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 vld_q, vld_d;

  for (genvar g = 0; g < ACC_D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    vld_d    = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy          = 1'b1;
        {acc_d, sr_d} = {acc_adj, sr_q} << 1;
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        bcd_d   = acc_q[4*DIGITS-1:0];
        // Any nonzero digit above the visible ones means the value did not fit.
        ovf_d   = |acc_q[ACC_W-1:4*DIGITS];
        vld_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid = vld_q;
  assign bcd       = bcd_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire
